mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 multiplexer output path between two requesters.
- Owns the mux select. Grants one requester at a time and forwards that requester's line to a registered output.
- Bounds how long one requester holds the grant while the other waits.
- Sits directly in front of the 2:1 mux datapath and replaces any hand-driven select.

Parameters:
- WIDTH, 1, bit width of line0/line1/muxout.
- MAX_HOLD, 4, max consecutive granted cycles while the other requester is waiting. Legal range 1..255.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req0  input  1  requester 0 wants the shared path.
- req1  input  1  requester 1 wants the shared path.
- line0  input  WIDTH  requester 0 data.
- line1  input  WIDTH  requester 1 data.
- grant0  output  1  requester 0 owns the path (registered).
- grant1  output  1  requester 1 owns the path (registered).
- select  output  1  mux select: 0 = line0, 1 = line1 (registered).
- muxout  output  WIDTH  registered selected data.
- out_valid  output  1  muxout carries granted data.

Behaviour:
- Reset (reset_n=0 at a clk edge, at any time, including mid-grant), all of the following at that edge:
  - state=IDLE; grant0=0, grant1=0, select=0, out_valid=0, muxout=0.
  - Priority pointer prio=0 (requester 0 wins first tie); hold_cnt=0.
- States: IDLE, GNT0, GNT1. grant0 = (state==GNT0), grant1 = (state==GNT1), select = (state==GNT1). All are registered; no combinational path from req to grant.
- IDLE:
  - req0 & req1 -> GNT[prio].
  - Only req0 -> GNT0. Only req1 -> GNT1. Neither -> stay.
- GNTn (n granted, m the other):
  - reqn=0 -> GNTm if reqm=1, else IDLE.
  - reqn=1, reqm=1, hold_cnt==MAX_HOLD-1 -> GNTm (forced rotation).
  - Otherwise stay; hold_cnt increments only while reqm=1 and saturates at MAX_HOLD-1.
  - When reqm=0, hold_cnt holds 0, so an uncontended owner keeps the grant indefinitely.
- Leaving GNTn for any reason sets prio=m. Entering any GNT state clears hold_cnt to 0.
- Grant switch GNT0<->GNT1 takes zero idle cycles.
- Latency:
  - Request sampled at edge t -> grant visible after edge t.
  - muxout/out_valid lag grant by one cycle: out_valid(t+1) = grant active at t; muxout(t+1) = line[select] sampled at t.
  - When no grant: out_valid=0 and muxout holds its last value.
- Simultaneous events:
  - Owner drops its req in the same cycle the hold limit is hit -> treated as release; the result is the same (GNTm).
  - Both reqs drop -> IDLE.
- MAX_HOLD=1 -> under continuous contention the grant alternates every cycle.
- Invariant: grant0 & grant1 is never 1.

Test Plan:
- Reset check: drive req0=req1=1 with reset_n=0 for 2 edges -> grant0=grant1=0, select=0, out_valid=0, muxout=0. Release reset -> grant0=1 one edge later (prio=0).
- Single requester: req0=1 only, line0=1, held 10 cycles -> grant0=1 all 10 cycles, hold_cnt stays 0, muxout=1 with out_valid=1 from the cycle after grant. Drop req0 -> IDLE, out_valid=0 one cycle after grant0 falls.
- Contention, MAX_HOLD=4: req0=req1=1 continuously, line0=0, line1=1 -> grant pattern 0,0,0,0,1,1,1,1,0,... and select follows. muxout=0 for 4 cycles then 1 for 4 cycles, shifted one cycle from select.
- Voluntary release plus priority: GNT0 active, req1=1; drop req0 after 2 cycles -> GNT1 on the next edge with no IDLE gap. Drop req1, then raise req0=req1=1 together -> GNT0 granted (prio=0 after GNT1 released).
- Reset mid-grant: in GNT1 with hold_cnt=2, pulse reset_n=0 for one edge while req0=req1=1 -> all outputs reset. Next edge GNT0 (prio reset to 0), hold_cnt restarts at 0.
- MAX_HOLD=1: req0=req1=1 for 6 cycles -> grant alternates 0,1,0,1,0,1; grant0&grant1 never 1 (assertion every cycle).

Source files
------------

// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin arbiter owning a shared 2:1 mux with bounded hold time
module mux_share_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] line0,
    input  logic [WIDTH-1:0] line1,
    output logic             grant0,
    output logic             grant1,
    output logic             select,
    output logic [WIDTH-1:0] muxout,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_prio;
    logic             w_next_prio;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_next_hold;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_muxout;

    always_comb begin
        w_next_state = r_state;
        w_next_prio  = r_prio;
        w_next_hold  = r_hold_cnt;

        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_next_state = r_prio ? GNT1 : GNT0;
                end else if (req0) begin
                    w_next_state = GNT0;
                end else if (req1) begin
                    w_next_state = GNT1;
                end
            end
            GNT0: begin
                if (!req0) begin
                    w_next_state = req1 ? GNT1 : IDLE;
                end else if (req1 && (r_hold_cnt == HOLD_LIM)) begin
                    w_next_state = GNT1;
                end
            end
            GNT1: begin
                if (!req1) begin
                    w_next_state = req0 ? GNT0 : IDLE;
                end else if (req0 && (r_hold_cnt == HOLD_LIM)) begin
                    w_next_state = GNT0;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Whoever gives up the path loses the next tie.
        if ((r_state == GNT0) && (w_next_state != GNT0)) begin
            w_next_prio = 1'b1;
        end
        if ((r_state == GNT1) && (w_next_state != GNT1)) begin
            w_next_prio = 1'b0;
        end

        // Hold time only accrues while the other side is actually waiting.
        if (w_next_state != r_state) begin
            w_next_hold = 8'd0;
        end else if (r_state == GNT0) begin
            if (req1) begin
                w_next_hold = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : 8'(r_hold_cnt + 8'd1);
            end else begin
                w_next_hold = 8'd0;
            end
        end else if (r_state == GNT1) begin
            if (req0) begin
                w_next_hold = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : 8'(r_hold_cnt + 8'd1);
            end else begin
                w_next_hold = 8'd0;
            end
        end else begin
            w_next_hold = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_hold_cnt  <= 8'd0;
            r_out_valid <= 1'b0;
            r_muxout    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_prio      <= w_next_prio;
            r_hold_cnt  <= w_next_hold;
            r_out_valid <= (r_state != IDLE);
            if (r_state != IDLE) begin
                r_muxout <= (r_state == GNT1) ? line1 : line0;
            end
        end
    end

    assign grant0    = (r_state == GNT0);
    assign grant1    = (r_state == GNT1);
    assign select    = (r_state == GNT1);
    assign muxout    = r_muxout;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb/tb_mux_share_arbiter.sv - directed self-checking bench for mux_share_arbiter
module tb_mux_share_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0;
    logic       req1;
    logic [0:0] line0;
    logic [0:0] line1;

    logic       grant0_a, grant1_a, select_a, out_valid_a;
    logic [0:0] muxout_a;
    logic       grant0_b, grant1_b, select_b, out_valid_b;
    logic [0:0] muxout_b;

    int checks = 0;
    int errors = 0;

    mux_share_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .line0     (line0),
        .line1     (line1),
        .grant0    (grant0_a),
        .grant1    (grant1_a),
        .select    (select_a),
        .muxout    (muxout_a),
        .out_valid (out_valid_a)
    );

    mux_share_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .line0     (line0),
        .line1     (line1),
        .grant0    (grant0_b),
        .grant1    (grant1_b),
        .select    (select_b),
        .muxout    (muxout_b),
        .out_valid (out_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        assert (((grant0_a & grant1_a) !== 1'b1) && ((grant0_b & grant1_b) !== 1'b1)) else begin
            errors++;
            $error("FAIL onehot: observed a=%b%b b=%b%b expected not both granted",
                   grant0_a, grant1_a, grant0_b, grant1_b);
        end
    end

    initial begin
        logic exp_owner;
        logic prev_owner;

        // Reset held with both requests asserted
        reset_n = 1'b0;
        req0    = 1'b1;
        req1    = 1'b1;
        line0   = 1'b0;
        line1   = 1'b0;
        tick();
        tick();
        chk("rst_grant0", grant0_a, 0);
        chk("rst_grant1", grant1_a, 0);
        chk("rst_select", select_a, 0);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_muxout", muxout_a, 0);

        reset_n = 1'b1;
        tick();
        chk("rel_grant0", grant0_a, 1);
        chk("rel_grant1", grant1_a, 0);
        chk("rel_valid", out_valid_a, 0);

        // Single requester for 10 cycles
        req1  = 1'b0;
        line0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("single_grant0", grant0_a, 1);
            chk("single_hold", dut.r_hold_cnt, 0);
            chk("single_valid", out_valid_a, 1);
            chk("single_muxout", muxout_a, 1);
        end
        req0 = 1'b0;
        tick();
        chk("drop_grant0", grant0_a, 0);
        chk("drop_valid_lag", out_valid_a, 1);
        tick();
        chk("drop_valid", out_valid_a, 0);
        chk("drop_muxout_hold", muxout_a, 1);

        // Contention with MAX_HOLD=4 from a fresh priority pointer
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req0    = 1'b1;
        req1    = 1'b1;
        line0   = 1'b0;
        line1   = 1'b1;
        prev_owner = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_owner = ((k / 4) % 2) == 1;
            chk("cont_grant0", grant0_a, {31'd0, ~exp_owner});
            chk("cont_grant1", grant1_a, {31'd0, exp_owner});
            chk("cont_select", select_a, {31'd0, exp_owner});
            if (k > 0) begin
                chk("cont_valid", out_valid_a, 1);
                chk("cont_muxout", muxout_a, {31'd0, prev_owner});
            end
            prev_owner = exp_owner;
        end

        // Voluntary release with waiting requester, then priority check
        req1 = 1'b0;
        tick();
        chk("vol_own0", grant0_a, 1);
        req1 = 1'b1;
        tick();
        tick();
        chk("vol_hold2", dut.r_hold_cnt, 2);
        req0 = 1'b0;
        tick();
        chk("vol_sw_grant1", grant1_a, 1);
        chk("vol_sw_grant0", grant0_a, 0);
        req1 = 1'b0;
        tick();
        chk("vol_idle", grant1_a, 0);
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        chk("vol_prio_grant0", grant0_a, 1);

        // Reset in the middle of a GNT1 tenure
        req0 = 1'b0;
        tick();
        chk("mid_gnt1", grant1_a, 1);
        req0 = 1'b1;
        tick();
        tick();
        chk("mid_hold2", dut.r_hold_cnt, 2);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_grant0", grant0_a, 0);
        chk("mid_rst_grant1", grant1_a, 0);
        chk("mid_rst_select", select_a, 0);
        chk("mid_rst_valid", out_valid_a, 0);
        chk("mid_rst_muxout", muxout_a, 0);
        reset_n = 1'b1;
        tick();
        chk("mid_after_grant0", grant0_a, 1);
        chk("mid_after_hold", dut.r_hold_cnt, 0);

        // MAX_HOLD=1 alternates every cycle
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_owner = (k % 2) == 1;
            chk("mh1_grant0", grant0_b, {31'd0, ~exp_owner});
            chk("mh1_grant1", grant1_b, {31'd0, exp_owner});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
